// File: rtl/gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl.sv
// Ring oscillator measurement controller: enables the ring, lets it settle, then counts
// synchronized RO_IN rising edges over a latched window of CLK cycles and reports the count.
module gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RO_IN,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rise;
  logic [SET_W-1:0]       settle_cnt, settle_nxt;
  logic [WIN_W-1:0]       win_cnt, win_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   ovf_nxt;
  logic                   done_nxt;

  // Synchronizer and history run in every state so edge detection is primed before MEASURE.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], RO_IN};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    win_nxt    = win_cnt;
    count_nxt  = COUNT;
    ovf_nxt    = OVF;
    done_nxt   = 1'b0;
    if (state != IDLE && ABORT) begin
      state_nxt = IDLE;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START && !ABORT) begin
            state_nxt  = SETTLE;
            win_nxt    = WINDOW;
            settle_nxt = SET_W'(SETTLE_CYCLES - 1);
            count_nxt  = '0;
            ovf_nxt    = 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            if (win_cnt == '0) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = MEASURE;
            end
          end else begin
            settle_nxt = settle_cnt - SET_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            if (&COUNT) ovf_nxt = 1'b1;
            else        count_nxt = COUNT + CNT_W'(1);
          end
          // win_cnt holds the MEASURE cycles still to run, including this one.
          if (win_cnt == WIN_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            win_nxt = win_cnt - WIN_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      COUNT      <= '0;
      OVF        <= 1'b0;
      DONE       <= 1'b0;
      RO_EN      <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      win_cnt    <= win_nxt;
      COUNT      <= count_nxt;
      OVF        <= ovf_nxt;
      DONE       <= done_nxt;
      RO_EN      <= (state_nxt != IDLE);
    end
  end

  assign BUSY = RO_EN;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl.sv
// Scoreboard bench for the ring oscillator measurement controller (16-bit and 4-bit counter
// instances driven in parallel from one pre-generated RO_IN waveform).
module tb_gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl;

  localparam int S    = 8;
  localparam int N    = 2;
  localparam int MAXC = 12000;
  localparam int RND0 = 3000;

  logic        CLK, RN, START, ABORT, RO_IN;
  logic [15:0] WINDOW;
  logic        ro_en, busy, done, ovf;
  logic [15:0] count;
  logic        ro_en4, busy4, done4, ovf4;
  logic [3:0]  count4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit ro_seq [MAXC];

  typedef struct {
    int done_edge;
    int cnt16;
    bit ovf16;
    int cnt4;
    bit ovf4;
  } exp_t;
  exp_t sb_q[$];

  gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl #(
    .CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(S), .SYNC_STAGES(N)
  ) dut (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(ro_en), .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
  );

  gf180mcu_fd_sc_mcu9t5v0__ringosc_meas_ctrl #(
    .CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(S), .SYNC_STAGES(N)
  ) dut4 (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(ro_en4), .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // RO_IN value seen at rising edge k is ro_seq[k].
  initial begin
    RO_IN = 1'b0;
    forever begin
      @(negedge CLK);
      RO_IN = (cyc + 1 < MAXC) ? ro_seq[cyc+1] : 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // An edge is counted at clock edge k when the ring was low at k-N-1 and high at k-N
  // and edge k falls inside the MEASURE window t+S+1 .. t+S+W.
  function automatic exp_t model(input int t, input int w);
    exp_t e;
    int   raw;
    raw = 0;
    for (int k = t + S + 1; k <= t + S + w; k++)
      if (ro_seq[k-N] && !ro_seq[k-N-1]) raw++;
    e.done_edge = t + S + w + 1;
    e.cnt16     = (raw > 65535) ? 65535 : raw;
    e.ovf16     = (raw > 65535);
    e.cnt4      = (raw > 15) ? 15 : raw;
    e.ovf4      = (raw > 15);
    return e;
  endfunction

  task automatic issue(input int w, input bit expect_done, output int t);
    @(negedge CLK);
    START  = 1'b1;
    WINDOW = 16'(w);
    t      = cyc + 1;
    if (expect_done) sb_q.push_back(model(t, w));
    @(negedge CLK);
    START  = 1'b0;
    WINDOW = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge CLK);
    chk("done_within_budget", done, 1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ro_en"}, ro_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_ro_en4"}, ro_en4, 0);
    chk({tag, "_busy4"}, busy4, 0);
    chk({tag, "_count4"}, count4, 0);
    chk({tag, "_ovf4"}, ovf4, 0);
  endtask

  // Monitor: every DONE must match the oldest outstanding measurement.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done || done4) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=%0b done4=%0b with no measurement outstanding (cycle %0d)",
                   done, done4, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_edge", cyc + 1, e.done_edge);
          chk("done_both", {done, done4}, 2'b11);
          chk("count16", count, e.cnt16);
          chk("ovf16", ovf, e.ovf16);
          chk("count4", count4, e.cnt4);
          chk("ovf4", ovf4, e.ovf4);
          chk("done_ro_en_low", ro_en, 0);
          chk("done_busy_low", busy, 0);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t, n_en, n_busy, w, off, idx;
    bit   lvl;
    exp_t e;
    int   offs [5];

    for (int i = 0; i < RND0; i++) ro_seq[i] = ((i / 2) % 2) == 1;
    idx = RND0;
    lvl = 1'b0;
    while (idx < MAXC) begin
      int h;
      h = $urandom_range(2, 5);
      for (int j = 0; j < h && idx < MAXC; j++) begin
        ro_seq[idx] = lvl;
        idx++;
      end
      lvl = !lvl;
    end

    RN = 1'b0; START = 1'b0; ABORT = 1'b0; WINDOW = '0;
    repeat (3) @(negedge CLK);
    chk_idle_zero("reset");
    RN = 1'b1;
    repeat (4) @(negedge CLK);

    // Nominal: window 100, ring period 4.
    issue(100, 1'b1, t);
    n_en = 0;
    n_busy = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      n_en   += int'(ro_en);
      n_busy += int'(busy);
      @(negedge CLK);
    end
    chk("nominal_done_seen", done, 1);
    chk("nominal_ro_en_cycles", n_en, S + 100);
    chk("nominal_busy_cycles", n_busy, S + 100);

    // Zero-length window.
    issue(0, 1'b1, t);
    wait_done(50);

    // START pulses while busy must be ignored.
    offs = '{2, 5, S + 1, S + 20, S + 60};
    issue(60, 1'b1, t);
    foreach (offs[i]) begin
      while (cyc < t + offs[i] - 1) @(negedge CLK);
      START  = 1'b1;
      WINDOW = 16'($urandom);
      @(negedge CLK);
      START  = 1'b0;
    end
    wait_done(200);

    // Abort on MEASURE cycle 40.
    issue(100, 1'b0, t);
    while (cyc < t + S + 39) @(negedge CLK);
    chk("abort_busy_before", busy, 1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk_idle_zero("abort");
    repeat (130) @(negedge CLK);
    chk("abort_stays_idle", busy, 0);

    // START and ABORT together in IDLE: ABORT wins, result retained.
    issue(100, 1'b1, t);
    e = model(t, 100);
    wait_done(300);
    @(negedge CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    chk("collide_busy", busy, 0);
    chk("collide_ro_en", ro_en, 0);
    chk("collide_count", count, e.cnt16);
    chk("collide_count4", count4, e.cnt4);
    chk("collide_ovf4", ovf4, e.ovf4);
    repeat (5) @(negedge CLK);
    chk("collide_still_idle", busy, 0);

    // Asynchronous reset mid-measure.
    issue(100, 1'b1, t);
    repeat (S + 30) @(negedge CLK);
    chk("reset_mid_busy_before", ro_en, 1);
    #2 RN = 1'b0;
    #1 chk_idle_zero("reset_mid");
    sb_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RN = 1'b1;
    issue(100, 1'b1, t);
    chk("post_reset_nominal_count", model(t, 100).cnt16, 25);
    wait_done(300);

    // Randomized measurements over an irregular ring waveform.
    while (cyc < RND0) @(negedge CLK);
    for (int it = 0; it < 25; it++) begin
      w = $urandom_range(0, 200);
      if ($urandom_range(0, 4) == 0) begin
        issue(w, 1'b0, t);
        off = $urandom_range(1, S + w);
        while (cyc < t + off - 1) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("rand_abort_busy", busy, 0);
        chk("rand_abort_count", count, 0);
        chk("rand_abort_ovf4", ovf4, 0);
      end else begin
        issue(w, 1'b1, t);
        wait_done(S + w + 20);
      end
      repeat ($urandom_range(1, 4)) @(negedge CLK);
    end

    repeat (20) @(negedge CLK);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
